// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with clear, validated load,
// wrap/saturate end-of-range and carry/load-error pulses.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  carry,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] stepped;
  logic         ripple;
  logic         all9;
  logic         all0;
  logic         valid;

  // Ripple survives past the top digit only at the end of range.
  always_comb begin
    stepped = count;
    ripple  = 1'b1;
    all9    = 1'b1;
    all0    = 1'b1;
    valid   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count[4*i+:4] != 4'd9) all9 = 1'b0;
      if (count[4*i+:4] != 4'd0) all0 = 1'b0;
      if (load_val[4*i+:4] > 4'd9) valid = 1'b0;
      if (ripple) begin
        if (up) begin
          if (count[4*i+:4] == 4'd9) begin
            stepped[4*i+:4] = 4'd0;
          end else begin
            stepped[4*i+:4] = count[4*i+:4] + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (count[4*i+:4] == 4'd0) begin
            stepped[4*i+:4] = 4'd9;
          end else begin
            stepped[4*i+:4] = count[4*i+:4] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  assign tc = up ? all9 : all0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count    <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        if (valid) count <= load_val;
        else       load_err <= 1'b1;
      end else if (en) begin
        if (!ripple) begin
          count <= stepped;
        end else if (WRAP) begin
          count <= stepped;
          carry <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: 2-digit wrapping and 3-digit
// saturating instances against an integer reference model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_, en, up, clr, load;
  logic [7:0]  lv2;
  logic [11:0] lv3;
  logic [7:0]  cnt2;
  logic [11:0] cnt3;
  logic        tc2, tc3, cy2, cy3, le2, le3;

  int tests = 0;
  int fails = 0;
  int m2, m3;
  bit c2, c3, e2, e3;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut2 (
    .clk(clk), .rst_(rst_), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(lv2), .count(cnt2), .tc(tc2),
    .carry(cy2), .load_err(le2)
  );

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b0)) dut3 (
    .clk(clk), .rst_(rst_), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(lv3), .count(cnt3), .tc(tc3),
    .carry(cy3), .load_err(le3)
  );

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model(input int v, input int d,
                                input bit wrap,
                                input logic [31:0] lv,
                                output int nv, output bit c,
                                output bit le);
    int mx, val;
    bit ok;
    mx = 10 ** d - 1;
    nv = v;
    c = 0;
    le = 0;
    if (clr) begin
      nv = 0;
    end else if (load) begin
      ok = 1;
      val = 0;
      for (int k = d - 1; k >= 0; k--) begin
        if (lv[4*k+:4] > 4'd9) ok = 0;
        val = val * 10 + int'(lv[4*k+:4]);
      end
      if (ok) nv = val;
      else le = 1;
    end else if (en) begin
      if (up) begin
        if (v == mx) begin
          if (wrap) begin nv = 0; c = 1; end
        end else nv = v + 1;
      end else begin
        if (v == 0) begin
          if (wrap) begin nv = mx; c = 1; end
        end else nv = v - 1;
      end
    end
  endfunction

  task automatic step();
    int n2, n3;
    bit a, b, x, y;
    model(m2, 2, 1'b1, {24'b0, lv2}, n2, a, x);
    model(m3, 3, 1'b0, {20'b0, lv3}, n3, b, y);
    @(posedge clk);
    #1;
    m2 = n2; c2 = a; e2 = x;
    m3 = n3; c3 = b; e3 = y;
  endtask

  task automatic idle();
    clr = 0; load = 0; en = 0; up = 1;
  endtask

  task automatic test_reset();
    rst_ = 0;
    idle();
    lv2 = 8'h00; lv3 = 12'h000;
    #3;
    tests++;
    if (cnt2 !== 8'h00 || cnt3 !== 12'h000) begin
      fails++;
      $display("FAIL reset_count got %h/%h want 00/000", cnt2, cnt3);
    end
    tests++;
    if ({cy2, le2, cy3, le3} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 0000",
               {cy2, le2, cy3, le3});
    end
    m2 = 0; m3 = 0; c2 = 0; c3 = 0; e2 = 0; e3 = 0;
    #9 rst_ = 1;
    step();
  endtask

  task automatic test_count_up();
    int ncy;
    ncy = 0;
    idle();
    clr = 1;
    step();
    clr = 0; en = 1; up = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      tests++;
      if (cnt2 !== 8'(to_bcd((i + 1) % 100))) begin
        fails++;
        $display("FAIL up_count i=%0d got %h want %h",
                 i, cnt2, 8'(to_bcd((i + 1) % 100)));
      end
      if (cy2) ncy++;
      if (cy2 !== (i == 99) || tc2 !== (m2 == 99)) begin
        tests++;
        fails++;
        $display("FAIL up_flags i=%0d carry=%b tc=%b want %b/%b",
                 i, cy2, tc2, i == 99, m2 == 99);
      end
    end
    tests++;
    if (ncy != 1) begin
      fails++;
      $display("FAIL up_carry_count got %0d want 1", ncy);
    end
  endtask

  task automatic test_count_down();
    logic [7:0] want [3];
    want[0] = 8'h99; want[1] = 8'h98; want[2] = 8'h97;
    idle();
    load = 1; lv2 = 8'h00;
    step();
    load = 0; en = 1; up = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (cnt2 !== want[i] || cy2 !== (i == 0)) begin
        fails++;
        $display("FAIL down i=%0d got %h c=%b want %h c=%b",
                 i, cnt2, cy2, want[i], i == 0);
      end
    end
  endtask

  task automatic test_saturate();
    idle();
    load = 1; lv3 = 12'h998; lv2 = 8'h12;
    step();
    load = 0; en = 1; up = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (cnt3 !== 12'h999 || cy3 !== 1'b0 || tc3 !== 1'b1) begin
        fails++;
        $display("FAIL sat i=%0d got %h c=%b tc=%b want 999 0 1",
                 i, cnt3, cy3, tc3);
      end
    end
    up = 0;
    step();
    tests++;
    if (cnt3 !== 12'h998) begin
      fails++;
      $display("FAIL sat_down got %h want 998", cnt3);
    end
  endtask

  task automatic test_load_err();
    idle();
    load = 1; lv2 = 8'h42;
    step();
    lv2 = 8'h3A;
    step();
    tests++;
    if (cnt2 !== 8'h42 || le2 !== 1'b1) begin
      fails++;
      $display("FAIL bad_load got %h err=%b want 42 1", cnt2, le2);
    end
    load = 0;
    step();
    tests++;
    if (cnt2 !== 8'h42 || le2 !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse got %h err=%b want 42 0", cnt2, le2);
    end
    load = 1; lv2 = 8'h57;
    step();
    tests++;
    if (cnt2 !== 8'h57 || le2 !== 1'b0) begin
      fails++;
      $display("FAIL good_load got %h err=%b want 57 0", cnt2, le2);
    end
  endtask

  task automatic test_priority();
    idle();
    load = 1; lv2 = 8'h25;
    step();
    clr = 1; load = 1; en = 1; lv2 = 8'h11;
    step();
    tests++;
    if (cnt2 !== 8'h00) begin
      fails++;
      $display("FAIL prio_clr got %h want 00", cnt2);
    end
    clr = 0;
    step();
    tests++;
    if (cnt2 !== 8'h11) begin
      fails++;
      $display("FAIL prio_load got %h want 11", cnt2);
    end
  endtask

  task automatic test_async_reset();
    idle();
    load = 1; lv2 = 8'h63;
    step();
    load = 0; en = 1; up = 1;
    #2 rst_ = 0;
    #1;
    tests++;
    if (cnt2 !== 8'h00 || {cy2, le2} !== 2'b00) begin
      fails++;
      $display("FAIL async_rst got %h c=%b e=%b want 00 0 0",
               cnt2, cy2, le2);
    end
    m2 = 0; m3 = 0; c2 = 0; c3 = 0; e2 = 0; e3 = 0;
    #1 rst_ = 1;
    step();
    tests++;
    if (cnt2 !== 8'h01) begin
      fails++;
      $display("FAIL post_rst got %h want 01", cnt2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom % 16) == 0;
      load = ($urandom % 8) == 0;
      en   = ($urandom % 4) != 0;
      up   = 1'($urandom % 2);
      if ($urandom % 2) begin
        lv2 = 8'(to_bcd($urandom % 100));
        lv3 = 12'(to_bcd($urandom % 1000));
      end else begin
        lv2 = 8'($urandom);
        lv3 = 12'($urandom);
      end
      step();
      tests++;
      if (cnt2 !== 8'(to_bcd(m2)) || cy2 !== c2 || le2 !== e2 ||
          tc2 !== (up ? m2 == 99 : m2 == 0)) begin
        fails++;
        $display("FAIL rand2 i=%0d got %h c%b e%b t%b want %h c%b e%b",
                 i, cnt2, cy2, le2, tc2, 8'(to_bcd(m2)), c2, e2);
      end
      tests++;
      if (cnt3 !== 12'(to_bcd(m3)) || cy3 !== c3 || le3 !== e3 ||
          tc3 !== (up ? m3 == 999 : m3 == 0)) begin
        fails++;
        $display("FAIL rand3 i=%0d got %h c%b e%b t%b want %h c%b e%b",
                 i, cnt3, cy3, le3, tc3, 12'(to_bcd(m3)), c3, e3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_err();
    test_priority();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
